buzzer_sequencer: RTL and testbench
===================================

// Module: buzzer_sequencer
// PURPOSE
//  Shares the single board buzzer between NREQ requesters. A round-robin arbiter
//  grants one requester at a time. The granted requester's tone period and
//  duration are latched, a square wave is generated on the buzzer, and a
//  fixed silent gap follows before the next grant.
//  Sits between the user/peripheral logic and the buzzer pin.
//  Buzzer is driven active-low, as on the board: 1 = silent.
// PARAMETERS
//  NREQ     4    number of requesters (>=2)
//  HALF_W   16   width of half-period field, in clk cycles
//  DUR_W    24   width of duration field, in clk cycles
//  GAP_CYC  1000 silent cycles after each beep (>=1)
// PORTS
//  clk       in   1            system clock
//  rst       in   1            synchronous reset, active-high
//  req       in   NREQ         level request per requester
//  req_half  in   NREQ*HALF_W  half-period per requester; slice i = [i*HALF_W +: HALF_W]
//  req_dur   in   NREQ*DUR_W   tone duration per requester; slice i = [i*DUR_W +: DUR_W]
//  grant     out  NREQ         one-hot; asserted for the whole TONE state
//  done      out  NREQ         one-cycle pulse for the requester whose beep completed
//  busy      out  1            1 in any state other than IDLE
//  buzzer    out  1            buzzer drive, active-low (0 = diaphragm pulled)
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous and active-high, on clk/rst.
//  - Reset, including mid-TONE or mid-GAP:
//    - Next edge: state=IDLE, buzzer=1, grant=0, done=0, busy=0, counters=0.
//    - rr_ptr=NREQ-1, so requester 0 has top priority first.
//  - FSM states: IDLE -> TONE -> GAP -> IDLE.
//  - IDLE, when any req bit is high:
//    - Select the first set bit searching upward from rr_ptr+1, with wrap-around.
//    - Latch its half/dur values. Set rr_ptr to the winner.
//    - Next cycle: state=TONE, grant=onehot(winner), buzzer=0.
//  - IDLE with no req: stay in IDLE, outputs hold their idle values. Latency req->grant = 1 cycle.
//  - TONE:
//    - buzzer toggles every half cycles; half=0 is treated as 1.
//    - TONE lasts exactly dur cycles, counted from the first TONE cycle.
//    - dur=0 is treated as 1.
//  - After the last TONE cycle:
//    - state=GAP, grant=0, buzzer=1.
//    - done[winner]=1 for the first GAP cycle only.
//  - GAP lasts GAP_CYC cycles, buzzer=1, then returns to IDLE.
//    - Arbitration happens in the IDLE cycle, so back-to-back beeps are spaced by GAP_CYC+1 silent cycles.
//  - Non-preemptive: req and latched values changing during TONE do not affect the beep (unless the optional macro below is enabled).
//  - Simultaneous requests are resolved by round-robin only. A held request is re-granted after every other active requester has been served once.
//  - Counters: the half counter is HALF_W bits, the dur counter is DUR_W bits, compared against latched values with no overflow.
//  - busy=1 in TONE and GAP.
// CONFIGURATION
//  BUZZER_ABORT_EN (macro):
//  - Defined: if req[winner] deasserts during TONE:
//    - Next cycle: state=GAP, buzzer=1, grant=0.
//    - done is NOT pulsed for the aborted beep.
//    - GAP length is unchanged.
//  - Undefined: req deassertion during TONE is ignored; the beep always runs its full duration and done is pulsed.
// TESTING (NREQ=4, GAP_CYC=4)
//  1) Assert rst mid-TONE: next cycle buzzer=1, grant=0, busy=0. Then req=0001 -> grant=0001 one cycle later.
//  2) req=0010, half=3, dur=12:
//     - buzzer = 0,0,0,1,1,1 repeated for 12 cycles.
//     - done=0010 for 1 cycle, then 4 GAP cycles, then IDLE.
//  3) req=1111 held, all dur=2: grant order 0001,0010,0100,1000,0001. Each grant starts 7 cycles after the previous one.
//  4) half=0, dur=0 on req0: one TONE cycle with buzzer=0, then done=0001.
//  5) With BUZZER_ABORT_EN, dur=100, drop req at TONE cycle 5:
//     - buzzer=1 and state=GAP next cycle; done stays 0.
//     - Without the macro: full 100-cycle tone and a done pulse.
//  6) Change req_half/req_dur mid-TONE: the waveform keeps the latched values.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// Round-robin arbiter sharing one active-low buzzer between NREQ requesters.
// Optional macro BUZZER_ABORT_EN: dropping req[winner] during TONE ends the beep early (no done).
module buzzer_sequencer #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned HALF_W  = 16,
  parameter int unsigned DUR_W   = 24,
  parameter int unsigned GAP_CYC = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*HALF_W-1:0]   req_half,
  input  logic [NREQ*DUR_W-1:0]    req_dur,
  output logic [NREQ-1:0]          grant,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic                     buzzer
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_TONE, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [HALF_W-1:0]  half_q, half_d, hcnt_q, hcnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d, dcnt_q, dcnt_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic               buzz_q, buzz_d;
  logic [NREQ-1:0]    done_q, done_d;

  logic [HALF_W-1:0]  half_a [NREQ];
  logic [DUR_W-1:0]   dur_a  [NREQ];
  logic [PTR_W-1:0]   pick, cand;
  logic               found;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign half_a[g] = req_half[g*HALF_W +: HALF_W];
    assign dur_a[g]  = req_dur[g*DUR_W +: DUR_W];
  end

  // rr_ptr doubles as the winner index for the current beep.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    half_d  = half_q;
    dur_d   = dur_q;
    hcnt_d  = hcnt_q;
    dcnt_d  = dcnt_q;
    gcnt_d  = gcnt_q;
    buzz_d  = buzz_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        buzz_d = 1'b1;
        if (found) begin
          state_d = S_TONE;
          ptr_d   = pick;
          half_d  = (half_a[pick] == '0) ? HALF_W'(1) : half_a[pick];
          dur_d   = (dur_a[pick] == '0) ? DUR_W'(1) : dur_a[pick];
          hcnt_d  = '0;
          dcnt_d  = '0;
          buzz_d  = 1'b0;
        end
      end
      S_TONE: begin
`ifdef BUZZER_ABORT_EN
        if (!req[ptr_q]) begin
          state_d = S_GAP;
          buzz_d  = 1'b1;
          gcnt_d  = '0;
          hcnt_d  = '0;
          dcnt_d  = '0;
        end else
`endif
        if (dcnt_q == dur_q - 1'b1) begin
          state_d       = S_GAP;
          buzz_d        = 1'b1;
          gcnt_d        = '0;
          hcnt_d        = '0;
          dcnt_d        = '0;
          done_d[ptr_q] = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
          if (hcnt_q == half_q - 1'b1) begin
            hcnt_d = '0;
            buzz_d = ~buzz_q;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        buzz_d = 1'b1;
        if (gcnt_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        buzz_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= PTR_W'(NREQ - 1);
      half_q  <= '0;
      dur_q   <= '0;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      gcnt_q  <= '0;
      buzz_q  <= 1'b1;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      half_q  <= half_d;
      dur_q   <= dur_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      gcnt_q  <= gcnt_d;
      buzz_q  <= buzz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == S_TONE) grant[ptr_q] = 1'b1;
  end

  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);
  assign buzzer = buzz_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: stimulus pushes expected beeps, a monitor checks the waveform.
module tb_buzzer_sequencer;

  localparam int unsigned NREQ = 4;
  localparam int unsigned HW   = 8;
  localparam int unsigned DW   = 12;
  localparam int unsigned GAP  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*HW-1:0]   req_half = '0;
  logic [NREQ*DW-1:0]   req_dur = '0;
  logic [NREQ-1:0]      grant, done;
  logic                 busy, buzzer;

  buzzer_sequencer #(.NREQ(NREQ), .HALF_W(HW), .DUR_W(DW), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_half(req_half), .req_dur(req_dur),
    .grant(grant), .done(done), .busy(busy), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int unsigned win;
    int unsigned half;
    int unsigned dur;
    int unsigned start;
  } exp_t;

  exp_t        sb[$];
  int unsigned mptr;
  int unsigned hv[NREQ];
  int unsigned dv[NREQ];

  function automatic int unsigned eff(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  // Next requester after the last winner, wrapping around.
  function automatic int unsigned rr_pick(input logic [NREQ-1:0] m, input int unsigned p);
    int unsigned c;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      c = (p + i) % NREQ;
      if (m[c]) return c;
    end
    return p;
  endfunction

  task automatic drive_fields();
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_half[i*HW +: HW] = HW'(hv[i]);
      req_dur[i*DW +: DW]  = DW'(dv[i]);
    end
  endtask

  task automatic scramble();
    for (int unsigned i = 0; i < NREQ; i++) begin
      hv[i] = $urandom_range(0, 6);
      dv[i] = $urandom_range(0, 20);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the next idle negedge.
  task automatic issue(input logic [NREQ-1:0] mask, input bit mid_change);
    exp_t e;
    e.win   = rr_pick(mask, mptr);
    e.half  = eff(hv[e.win]);
    e.dur   = eff(dv[e.win]);
    e.start = cyc + 1;
    mptr    = e.win;
    sb.push_back(e);
    req = mask;
    drive_fields();
    @(negedge clk);
    if (mid_change) begin
      scramble();
      drive_fields();
    end
    repeat (e.dur) @(negedge clk);
    req = '0;
    repeat (GAP) @(negedge clk);
  endtask

  // Monitor
  bit          mon_en = 1'b0;
  int unsigned phase  = 0;
  int unsigned k      = 0;
  exp_t        cur;

  always @(negedge clk) begin
    if (mon_en) begin
      if (phase == 1) begin
        if (grant != '0 && k < cur.dur) begin
          chk("tone_grant", grant, NREQ'(1) << cur.win);
          chk("tone_buzzer", buzzer, ((k / cur.half) % 2));
          chk("tone_done", done, 0);
          chk("tone_busy", busy, 1);
          k++;
        end else begin
          chk("tone_len", k, cur.dur);
          chk("done_pulse", done, NREQ'(1) << cur.win);
          chk("gap_buzzer", buzzer, 1);
          chk("gap_grant", grant, 0);
          chk("gap_busy", busy, 1);
          phase = 0;
        end
      end else if (grant != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", grant, 0);
        end else begin
          cur = sb.pop_front();
          chk("grant_start", cyc, cur.start);
          chk("grant_id", grant, NREQ'(1) << cur.win);
          chk("tone_buzzer", buzzer, 0);
          chk("tone_done", done, 0);
          k     = 1;
          phase = 1;
        end
      end else begin
        chk("idle_done", done, 0);
        chk("idle_buzzer", buzzer, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    exp_t        e;

    // Reset state and mid-TONE reset
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_buzzer", buzzer, 1);
    chk("rst_done", done, 0);
    rst = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin hv[i] = 2; dv[i] = 20; end
    drive_fields();
    req = 4'b0010;
    @(negedge clk);
    chk("latency_grant", grant, 4'b0010);
    chk("latency_buzzer", buzzer, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_buzzer", buzzer, 1);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    chk("ptr_reset_grant", grant, 4'b0001);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst  = 1'b0;
    mptr = NREQ - 1;
    mon_en = 1'b1;
    @(negedge clk);

    // Fixed half=3, dur=12 on requester 1
    for (int unsigned i = 0; i < NREQ; i++) begin hv[i] = 3; dv[i] = 12; end
    issue(4'b0010, 1'b0);

    // half=0, dur=0 on requester 0
    hv[0] = 0; dv[0] = 0;
    issue(4'b0001, 1'b0);

    // All requesters held, dur=2: back-to-back round-robin
    for (int unsigned i = 0; i < NREQ; i++) begin hv[i] = 1 + i; dv[i] = 2; end
    n0 = cyc;
    for (int unsigned j = 0; j < 5; j++) begin
      e.win   = rr_pick(4'b1111, mptr);
      e.half  = hv[e.win];
      e.dur   = 2;
      e.start = n0 + 1 + j * (2 + GAP + 1);
      mptr    = e.win;
      sb.push_back(e);
    end
    req = 4'b1111;
    drive_fields();
    repeat (1 + 4 * (2 + GAP + 1) + 2) @(negedge clk);
    req = '0;
    repeat (GAP) @(negedge clk);

    // Random beeps, with fields changed mid-tone
    for (int unsigned it = 0; it < 40; it++) begin
      scramble();
      issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("monitor_idle", phase, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
